// File: rtl/avalon_input_pio_pkg.sv
// ----------------------------------------------------------------------------
// avalon_input_pio_pkg
// Shared definitions for the Avalon-MM input PIO: register word addresses,
// the edge-mode encoding held in CONFIG[1:0], the CONFIG reset value and a
// per-bit edge qualification helper.
// ----------------------------------------------------------------------------
package avalon_input_pio_pkg;

    // Register word addresses
    localparam logic [1:0] ADDR_DATA         = 2'd0;
    localparam logic [1:0] ADDR_IRQ_MASK     = 2'd1;
    localparam logic [1:0] ADDR_EDGE_CAPTURE = 2'd2;
    localparam logic [1:0] ADDR_CONFIG       = 2'd3;

    // CONFIG[1:0] edge selection
    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_ANY  = 2'b10,
        EDGE_NONE = 2'b11
    } edge_mode_t;

    // Debounce enabled, rising-edge capture
    localparam logic [2:0] CONFIG_RESET = 3'b100;

    // Returns 1 when the transition prev -> cur qualifies under the mode
    function automatic logic edge_qualify(input edge_mode_t mode,
                                          input logic       cur,
                                          input logic       prev);
        logic q;
        case (mode)
            EDGE_RISE: q = cur & ~prev;
            EDGE_FALL: q = ~cur & prev;
            EDGE_ANY:  q = cur ^ prev;
            EDGE_NONE: q = 1'b0;
            default:   q = 1'b0;
        endcase
        return q;
    endfunction

endpackage

// File: rtl/avalon_input_pio_debounce.sv
// ----------------------------------------------------------------------------
// input_debounce
// One input channel: SYNC_STAGES-flop synchroniser, debounce counter and
// stable-level register. A new synchronised level is accepted only after it
// has differed from the stable level for DEBOUNCE_CYCLES consecutive edges.
// Ports:
//   clk      system clock
//   reset_n  synchronous active-low reset
//   enable   1 = debounce filter active, 0 = stable follows sync every cycle
//   clr      clears the debounce counter (stable level retained)
//   din      asynchronous input
//   dout     debounced stable level
// ----------------------------------------------------------------------------
module input_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic clr,
    input  logic din,
    output logic dout
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] TERMINAL = CW'(DEBOUNCE_CYCLES - 1);
    // With a one-cycle debounce the filter degenerates to a plain register
    localparam logic NO_FILTER = (DEBOUNCE_CYCLES <= 1) ? 1'b1 : 1'b0;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_count;
    logic                   r_stable;
    logic                   w_sync;
    logic                   w_bypass;

    assign w_sync   = r_sync[SYNC_STAGES-1];
    assign w_bypass = NO_FILTER | ~enable;

    // Synchroniser shift chain, din enters at bit 0
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], din};
        end
    end

    // Debounce counter and stable level
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count  <= '0;
            r_stable <= 1'b0;
        end else if (w_bypass) begin
            r_count  <= '0;
            r_stable <= w_sync;
        end else if (clr) begin
            r_count  <= '0;
        end else if (w_sync == r_stable) begin
            r_count  <= '0;
        end else if (r_count == TERMINAL) begin
            // Level held for the full window: accept it
            r_count  <= '0;
            r_stable <= w_sync;
        end else begin
            r_count  <= r_count + CW'(1);
        end
    end

    assign dout = r_stable;

endmodule

// File: rtl/avalon_input_pio.sv
// ----------------------------------------------------------------------------
// avalon_input_pio
// Avalon-MM input PIO: WIDTH synchronised and debounced inputs, sticky edge
// capture (write-1-to-clear), interrupt mask and a level interrupt.
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   address[1:0]            0 DATA, 1 IRQ_MASK, 2 EDGE_CAPTURE, 3 CONFIG
//   chipselect, read, write slave select and strobes
//   writedata[31:0]         write data
//   readdata[31:0]          registered read data (latency 1)
//   in_port[WIDTH-1:0]      asynchronous external inputs
//   irq                     active-high level interrupt
// ----------------------------------------------------------------------------
module avalon_input_pio
    import avalon_input_pio_pkg::*;
#(
    parameter int WIDTH           = 3,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_cap;
    logic [WIDTH-1:0] r_stable_d;
    logic [2:0]       r_config;
    logic [31:0]      r_readdata;

    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_w1c;
    logic [31:0]      w_rdmux;
    logic             w_cs_wr;
    logic             w_cs_rd;
    logic             w_wr_config;
    edge_mode_t       w_mode;
    logic             w_unused_wdata;

    assign w_cs_wr     = chipselect & write;
    assign w_cs_rd     = chipselect & read;
    assign w_wr_config = w_cs_wr & (address == ADDR_CONFIG);
    assign w_mode      = edge_mode_t'(r_config[1:0]);
    // Upper writedata bits have no destination for narrow instances
    assign w_unused_wdata = ^writedata;

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_chan
            input_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .SYNC_STAGES    (SYNC_STAGES)
            ) u_debounce (
                .clk    (clk),
                .reset_n(reset_n),
                .enable (r_config[2]),
                .clr    (w_wr_config),
                .din    (in_port[g]),
                .dout   (w_stable[g])
            );
        end
    endgenerate

    // Qualify each channel's stable-level transition against the edge mode
    always_comb begin
        w_edge = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_edge[i] = edge_qualify(w_mode, w_stable[i], r_stable_d[i]);
        end
    end

    // Bits to clear on an EDGE_CAPTURE write
    always_comb begin
        if (w_cs_wr && (address == ADDR_EDGE_CAPTURE)) begin
            w_w1c = writedata[WIDTH-1:0];
        end else begin
            w_w1c = '0;
        end
    end

    // Register file, edge delay and sticky capture (set beats clear)
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_mask     <= '0;
            r_cap      <= '0;
            r_config   <= CONFIG_RESET;
            r_stable_d <= '0;
        end else begin
            r_stable_d <= w_stable;
            r_cap      <= (r_cap & ~w_w1c) | w_edge;
            if (w_cs_wr && (address == ADDR_IRQ_MASK)) begin
                r_mask <= writedata[WIDTH-1:0];
            end
            if (w_wr_config) begin
                r_config <= writedata[2:0];
            end
        end
    end

    // Read multiplexer, unused bits read as zero
    always_comb begin
        w_rdmux = 32'd0;
        case (address)
            ADDR_DATA:         w_rdmux[WIDTH-1:0] = w_stable;
            ADDR_IRQ_MASK:     w_rdmux[WIDTH-1:0] = r_mask;
            ADDR_EDGE_CAPTURE: w_rdmux[WIDTH-1:0] = r_cap;
            ADDR_CONFIG:       w_rdmux[2:0]       = r_config;
            default:           w_rdmux            = 32'd0;
        endcase
    end

    // Registered read data; samples pre-write values on a same-cycle write
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_readdata <= 32'd0;
        end else if (w_cs_rd) begin
            r_readdata <= w_rdmux;
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_cap & r_mask);

endmodule

// File: tb/tb_avalon_input_pio.sv
// ----------------------------------------------------------------------------
// tb_avalon_input_pio
// Directed checks of the register map, debounce timing, edge modes, W1C
// collision, bypass and reset, followed by randomised input toggling checked
// against a history-based reference model.
// ----------------------------------------------------------------------------
module tb_avalon_input_pio;
    import avalon_input_pio_pkg::*;

    localparam int W  = 3;
    localparam int D  = 4;
    localparam int S  = 2;
    localparam int NR = 150;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [W-1:0] in_port;
    logic        irq;

    int tests = 0;
    int fails = 0;

    // Reference model state: input history and expected stable levels
    logic [W-1:0] hist [0:NR+11];
    logic [W-1:0] mst  [0:NR+11];
    logic [W-1:0] mcap;
    logic [W-1:0] mcap_pre;
    logic [W-1:0] drv;
    logic [31:0]  rdv;
    logic         seen;

    always #5 clk = ~clk;

    avalon_input_pio #(
        .WIDTH(W), .DEBOUNCE_CYCLES(D), .SYNC_STAGES(S)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .read(read), .write(write),
        .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .irq(irq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp, input string tag);
        chipselect = 1'b1; read = 1'b1; address = a;
        tick();
        chipselect = 1'b0; read = 1'b0;
        check(tag, readdata, exp);
    endtask

    function automatic logic [W-1:0] model_edges(input int m, input logic [W-1:0] nw,
                                                 input logic [W-1:0] old);
        case (m)
            0:       return nw & ~old;
            1:       return ~nw & old;
            2:       return nw ^ old;
            default: return '0;
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        address = 2'd0; writedata = 32'd0; in_port = '0;
        repeat (3) tick();
        reset_n = 1'b1;

        // Reset state
        check("rst_readdata", readdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rd_chk(ADDR_DATA, 32'd0, "rst_data");
        rd_chk(ADDR_IRQ_MASK, 32'd0, "rst_mask");
        rd_chk(ADDR_EDGE_CAPTURE, 32'd0, "rst_cap");
        rd_chk(ADDR_CONFIG, 32'd4, "rst_config");

        // Step on channel 0: DATA after 6 edges, capture/irq one edge later
        wr(ADDR_IRQ_MASK, 32'd1);
        chipselect = 1'b1; read = 1'b1; address = ADDR_DATA; in_port = 3'b001;
        repeat (6) tick();
        check("step_data_e6", readdata, 32'd0);
        check("step_irq_e6", {31'd0, irq}, 32'd0);
        tick();
        check("step_data_e7", readdata, 32'd1);
        check("step_irq_e7", {31'd0, irq}, 32'd1);
        chipselect = 1'b0; read = 1'b0;
        rd_chk(ADDR_EDGE_CAPTURE, 32'd1, "step_cap");
        wr(ADDR_EDGE_CAPTURE, 32'd1);
        rd_chk(ADDR_EDGE_CAPTURE, 32'd0, "step_cap_w1c");
        check("step_irq_clr", {31'd0, irq}, 32'd0);

        // 3-cycle pulse on channel 1 must be filtered
        seen = 1'b0;
        chipselect = 1'b1; read = 1'b1; address = ADDR_DATA; in_port = 3'b011;
        repeat (3) begin tick(); seen = seen | readdata[1]; end
        in_port = 3'b001;
        repeat (10) begin tick(); seen = seen | readdata[1]; end
        check("glitch3_data", {31'd0, seen}, 32'd0);
        chipselect = 1'b0; read = 1'b0;
        rd_chk(ADDR_EDGE_CAPTURE, 32'd0, "glitch3_cap");

        // 4-cycle pulse on channel 1 is accepted
        chipselect = 1'b1; read = 1'b1; address = ADDR_DATA; in_port = 3'b011;
        repeat (4) tick();
        in_port = 3'b001;
        repeat (3) tick();
        check("pulse4_data", readdata, 32'd3);
        repeat (10) tick();
        check("pulse4_data_back", readdata, 32'd1);
        chipselect = 1'b0; read = 1'b0;
        rd_chk(ADDR_EDGE_CAPTURE, 32'd2, "pulse4_cap");
        wr(ADDR_EDGE_CAPTURE, 32'd7);

        // Falling-edge mode on channel 2
        wr(ADDR_CONFIG, 32'd5);
        in_port = 3'b101;
        repeat (12) tick();
        rd_chk(ADDR_DATA, 32'd5, "fall_data_hi");
        rd_chk(ADDR_EDGE_CAPTURE, 32'd0, "fall_no_rise");
        in_port = 3'b001;
        repeat (12) tick();
        rd_chk(ADDR_EDGE_CAPTURE, 32'd4, "fall_cap");
        wr(ADDR_EDGE_CAPTURE, 32'd7);

        // No-edge mode
        wr(ADDR_CONFIG, 32'd7);
        in_port = 3'b101;
        repeat (12) tick();
        rd_chk(ADDR_DATA, 32'd5, "none_data_hi");
        in_port = 3'b001;
        repeat (12) tick();
        rd_chk(ADDR_DATA, 32'd1, "none_data_lo");
        rd_chk(ADDR_EDGE_CAPTURE, 32'd0, "none_cap");

        // Same-cycle read and write returns pre-write value
        chipselect = 1'b1; read = 1'b1; write = 1'b1;
        address = ADDR_IRQ_MASK; writedata = 32'd7;
        tick();
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
        check("rdwr_old", readdata, 32'd1);
        rd_chk(ADDR_IRQ_MASK, 32'd7, "rdwr_new");
        wr(ADDR_IRQ_MASK, 32'd1);

        // W1C colliding with a new rising edge: set wins
        wr(ADDR_CONFIG, 32'd4);
        in_port = 3'b000;
        repeat (12) tick();
        wr(ADDR_EDGE_CAPTURE, 32'd7);
        rd_chk(ADDR_EDGE_CAPTURE, 32'd0, "coll_pre");
        in_port = 3'b001;
        repeat (6) tick();
        chipselect = 1'b1; write = 1'b1; address = ADDR_EDGE_CAPTURE; writedata = 32'd1;
        tick();
        chipselect = 1'b0; write = 1'b0;
        check("coll_irq", {31'd0, irq}, 32'd1);
        rd_chk(ADDR_EDGE_CAPTURE, 32'd1, "coll_set_wins");
        wr(ADDR_EDGE_CAPTURE, 32'd1);
        rd_chk(ADDR_EDGE_CAPTURE, 32'd0, "coll_clear");

        // Bypass: 1-cycle glitch visible 3 edges later
        wr(ADDR_CONFIG, 32'd0);
        in_port = 3'b000;
        repeat (12) tick();
        wr(ADDR_EDGE_CAPTURE, 32'd7);
        chipselect = 1'b1; read = 1'b1; address = ADDR_DATA; in_port = 3'b001;
        tick();
        in_port = 3'b000;
        tick();
        tick();
        check("byp_e3", readdata, 32'd0);
        tick();
        check("byp_e4", readdata, 32'd1);
        tick();
        check("byp_e5", readdata, 32'd0);
        chipselect = 1'b0; read = 1'b0;
        rd_chk(ADDR_EDGE_CAPTURE, 32'd1, "byp_cap");

        // Reset mid-debounce, input held high through reset
        wr(ADDR_IRQ_MASK, 32'd7);
        wr(ADDR_CONFIG, 32'd4);
        in_port = 3'b001;
        repeat (4) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("mrst_readdata", readdata, 32'd0);
        check("mrst_irq", {31'd0, irq}, 32'd0);
        rd_chk(ADDR_IRQ_MASK, 32'd0, "mrst_mask");
        rd_chk(ADDR_EDGE_CAPTURE, 32'd0, "mrst_cap");
        rd_chk(ADDR_CONFIG, 32'd4, "mrst_config");
        rd_chk(ADDR_DATA, 32'd0, "mrst_data");
        repeat (10) tick();
        rd_chk(ADDR_EDGE_CAPTURE, 32'd1, "held_cap");
        rd_chk(ADDR_DATA, 32'd1, "held_data");

        // Randomised toggling against the history model, one round per mode
        for (int m = 0; m < 4; m++) begin
            wr(ADDR_CONFIG, 32'(4 + m));
            in_port = '0;
            repeat (20) tick();
            wr(ADDR_IRQ_MASK, 32'd7);
            wr(ADDR_EDGE_CAPTURE, 32'd7);
            mcap = '0;
            drv  = '0;
            for (int i = 0; i < 10; i++) begin
                hist[i] = '0;
                mst[i]  = '0;
            end
            chipselect = 1'b1; read = 1'b1; address = ADDR_DATA;
            for (int n = 10; n <= 10 + NR; n++) begin
                if (n == 10 + NR) begin
                    address = ADDR_EDGE_CAPTURE;
                end else begin
                    for (int b = 0; b < W; b++) begin
                        if ($urandom_range(0, 3) == 0) drv[b] = ~drv[b];
                    end
                end
                in_port = drv;
                hist[n] = drv;
                tick();
                // A level is accepted once the last D synchronised samples all disagree
                for (int b = 0; b < W; b++) begin
                    logic all_new;
                    all_new = 1'b1;
                    for (int k = 0; k < D; k++) begin
                        if (hist[n-S-k][b] == mst[n-1][b]) all_new = 1'b0;
                    end
                    mst[n][b] = all_new ? ~mst[n-1][b] : mst[n-1][b];
                end
                mcap_pre = mcap;
                mcap = mcap | model_edges(m, mst[n-1], mst[n-2]);
                if (n == 10 + NR) begin
                    check("rnd_cap", readdata, 32'(mcap_pre));
                end else begin
                    check("rnd_data", readdata, 32'(mst[n-1]));
                end
                check("rnd_irq", {31'd0, irq}, {31'd0, |mcap});
            end
            chipselect = 1'b0; read = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/avalon_input_pio.md
# avalon_input_pio

Parametrised Avalon-MM input PIO that supersedes the plain button/switch PIOs in the Nios system. Synchronises WIDTH external inputs, debounces each channel with its own counter, records edges in a sticky capture register, and raises a maskable interrupt to the Nios II. One instance serves the push-buttons (edge/IRQ use) and one serves the slide switches (level use).

## Interface
- WIDTH, 3: number of input channels, 1..32.
- DEBOUNCE_CYCLES, 50000: cycles an input must hold a new level before it is accepted (1 ms at 50 MHz); minimum 1.
- SYNC_STAGES, 2: synchroniser flops per channel, minimum 2.
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- address  in  2  word address: 0 DATA, 1 IRQ_MASK, 2 EDGE_CAPTURE, 3 CONFIG.
- chipselect  in  1  slave select.
- read  in  1  read strobe, qualified by chipselect.
- write  in  1  write strobe, qualified by chipselect.
- writedata  in  32  write data.
- readdata  out  32  read data, registered.
- in_port  in  WIDTH  asynchronous external inputs.
- irq  out  1  level interrupt, active high.

## Operation
- Per channel: SYNC_STAGES-flop synchroniser -> debouncer -> stable level -> edge detector.
- Debouncer: counter clears while sync == stable; increments while they differ; on reaching DEBOUNCE_CYCLES-1 with sync still different, stable <= sync and counter clears. A glitch shorter than DEBOUNCE_CYCLES cycles never reaches stable.
- CONFIG[2] = 0 (debounce bypass) or DEBOUNCE_CYCLES = 1: stable <= sync every cycle.
- Edge mode CONFIG[1:0]: 00 rising, 01 falling, 10 any, 11 none.
- Edge detector compares stable with its one-cycle-delayed copy; a qualifying edge sets the EDGE_CAPTURE bit.
- DATA (RO): stable levels in bits [WIDTH-1:0]; writes ignored.
- IRQ_MASK (RW): bits [WIDTH-1:0].
- EDGE_CAPTURE: write-1-to-clear; writing 0 bits leaves them unchanged.
- CONFIG (RW): bits [2:0]; any CONFIG write clears all debounce counters (stable values retained).
- Unused readdata bits read 0.
- irq = |(EDGE_CAPTURE & IRQ_MASK), driven directly from registers.
- Simultaneous W1C and new edge on the same bit: set wins, bit stays 1.
- Simultaneous read and write to the same register: read returns the pre-write value.
- Reset values: readdata 0, irq 0, IRQ_MASK 0, EDGE_CAPTURE 0, CONFIG 3'b100, sync/stable/delayed 0, counters 0.
- An input held high through reset is accepted after debounce and produces a rising-edge capture; software clears EDGE_CAPTURE after init.
- Reset asserted mid-debounce returns all state to reset values on the next edge.

## Timing
- Read latency 1: readdata valid on the cycle after chipselect & read; readdata holds its value otherwise.
- Writes take effect at the clock edge where chipselect & write are sampled; no wait states.
- in_port step at cycle 0 (stable thereafter): sync output changes after SYNC_STAGES edges; stable changes DEBOUNCE_CYCLES edges later; EDGE_CAPTURE bit set 1 edge after that; irq high in the same cycle as the bit.
- Bypass mode: stable changes SYNC_STAGES+1 edges after the input step.
- Counter width $clog2(DEBOUNCE_CYCLES), minimum 1 bit; no wrap possible, since the counter clears at terminal count.

## Structure
- Package avalon_input_pio_pkg: register address constants (ADDR_DATA, ADDR_IRQ_MASK, ADDR_EDGE_CAPTURE, ADDR_CONFIG), edge_mode_t enum (EDGE_RISE, EDGE_FALL, EDGE_ANY, EDGE_NONE), CONFIG_RESET = 3'b100.
- Sub-module input_debounce: one channel, comprising synchroniser, counter and stable register, with ports clk, reset_n, enable, clr, din, dout. Generated WIDTH times.
- Top level holds the register file, edge logic, read mux and irq.

## Test plan
Bench uses WIDTH=3, DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
- Reset with in_port=0 -> read DATA=0, IRQ_MASK=0, EDGE_CAPTURE=0, CONFIG=4; irq=0.
- in_port[0] 0->1 held, IRQ_MASK=1 -> DATA[0]=1 exactly 6 edges after the step; EDGE_CAPTURE=1 and irq=1 one edge later; write 1 to EDGE_CAPTURE -> reads 0, irq=0.
- in_port[1] high-pulse for 3 cycles -> DATA stays 0, EDGE_CAPTURE stays 0; a 4-cycle pulse -> DATA[1]=1.
- CONFIG=1 (falling), channel 2 toggles 0->1->0 with full-length holds -> only the falling edge sets EDGE_CAPTURE[2]=1; CONFIG=3 -> no capture on any toggle.
- W1C of bit 0 in the same cycle as a new rising edge on bit 0 -> EDGE_CAPTURE[0] remains 1.
- CONFIG=0 (bypass), 1-cycle glitch on in_port[0] -> DATA[0] shows it 3 edges later; reset_n low mid-debounce -> all registers return to reset values.
